// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard and a one-entry-per-cycle sweep-clear FSM.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and a same-cycle claim) onto the read ports.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              clr,
    output logic              clr_busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;

    logic wr_ok, cl_ok, inc, dec;
    logic zero1, zero2, fwd1, fwd2;

    assign wr_ok = we    && (state == IDLE) && !(HAS_ZERO && wr_addr    == '0);
    assign cl_ok = claim && (state == IDLE) && !(HAS_ZERO && claim_addr == '0);

    // Count bookkeeping: a claim adds one only if the target was free; a write
    // retires one only if its target was busy and is not being re-claimed.
    assign inc = cl_ok && !busy[claim_addr];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dec = 1'b0;
        if (state == SWEEP)
            dec = busy[ptr];
        else
            dec = wr_ok && busy[wr_addr] && !(cl_ok && claim_addr == wr_addr);
    end

    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[wr_addr]    = 1'b0;
        if (cl_ok) busy_nxt[claim_addr] = 1'b1;
    end

    // Control, scoreboard and pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy     <= busy_nxt;
                    busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
                    ptr      <= '0;
                    if (clr) state <= SWEEP;
                end
                SWEEP: begin
                    busy[ptr] <= 1'b0;
                    busy_cnt  <= busy_cnt - (ADDR_W+1)'(dec);
                    ptr       <= ptr + 1'b1;
                    if (ptr == PTR_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset explicitly because reset must leave every register reading zero.
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (state == SWEEP) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign clr_busy = (state == SWEEP);

    assign zero1 = HAS_ZERO && (rd_addr1 == '0);
    assign zero2 = HAS_ZERO && (rd_addr2 == '0);

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_ok && (rd_addr1 == wr_addr);
    assign fwd2 = wr_ok && (rd_addr2 == wr_addr);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // A forwarded read reports busy only when the same register is re-claimed this cycle.
    assign rd_data1 = zero1 ? '0 : fwd1 ? wr_data : mem[rd_addr1];
    assign rd_data2 = zero2 ? '0 : fwd2 ? wr_data : mem[rd_addr2];
    assign rd_busy1 = zero1 ? 1'b0 : fwd1 ? (cl_ok && claim_addr == rd_addr1) : busy[rd_addr1];
    assign rd_busy2 = zero2 ? 1'b0 : fwd2 ? (cl_ok && claim_addr == rd_addr2) : busy[rd_addr2];

endmodule
